// File: rtl/fb_arb_pkg.sv
// ============================================================================
//  Module   : fb_arb_pkg
//  Purpose  : Shared types and helpers for the framebuffer scan/host arbiter.
//             Holds the arbiter state encoding, the frame-size helper and the
//             memory-request record carried by the request register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fb_arb_pkg;

    // Widest address / data the request record can carry. The arbiter
    // refuses to elaborate with wider AW/DW.
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN_WAIT = 2'd1,
        HOST_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 we;
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with show-ahead read and occupancy count.
//             Push and pop in the same cycle leave the count unchanged.
//             Pop while empty and push while full are ignored. flush_i
//             empties the FIFO and overrides any push/pop in that cycle.
//  Ports    : clk_i, rst_ni       clock, async active-low reset
//             flush_i             empty the FIFO
//             push_i, wdata_i     write one entry
//             pop_i               consume the head entry
//             rdata_o, valid_o    head entry (0 when empty), non-empty flag
//             count_o             number of stored entries
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 16,   // power of two, >= 2
    parameter int DW    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push  = push_i && (count_q != DEPTH_C);
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is masked to 0 while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fb_scan_arbiter.sv
// ============================================================================
//  Module   : fb_scan_arbiter
//  Purpose  : Shares one single-port framebuffer between display scan-out
//             (linear prefetch into a pixel FIFO) and a host read/write port.
//             Scan-out is urgent below LOW_WM, host is served next, and the
//             FIFO is topped up opportunistically otherwise.
//  Ports    : clk_i, rst_ni                     clock, async active-low reset
//             frame_start_i                     restart scan-out at vsync
//             pix_rd_i, pix_o, pix_valid_o      show-ahead pixel stream
//             underrun_o                        sticky pop-while-empty flag
//             hreq_i/hwe_i/haddr_i/hdata_i      host request (held to ack)
//             hack_o, hrdata_o                  host completion, read data
//             mem_req_o/we/addr/wdata           memory request (held to ack)
//             mem_ack_i, mem_rdata_i            memory completion, read data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_scan_arbiter #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int AW         = 17,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          frame_start_i,
    input  logic          pix_rd_i,
    output logic [DW-1:0] pix_o,
    output logic          pix_valid_o,
    output logic          underrun_o,
    input  logic          hreq_i,
    input  logic          hwe_i,
    input  logic [AW-1:0] haddr_i,
    input  logic [DW-1:0] hdata_i,
    output logic          hack_o,
    output logic [DW-1:0] hrdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    import fb_arb_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] FRAME_LAST = AW'(frame_pixels(WIDTH, HEIGHT) - 1);
    localparam logic [CW-1:0] LOW_WM_C   = CW'(LOW_WM);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    if ((longint'(WIDTH) * longint'(HEIGHT)) > (longint'(1) << AW)) begin : g_frame_too_big
        $error("fb_scan_arbiter: WIDTH*HEIGHT exceeds 2**AW");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_not_pow2
        $error("fb_scan_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if ((AW > FB_ADDR_W) || (DW > FB_DATA_W)) begin : g_req_too_wide
        $error("fb_scan_arbiter: AW/DW exceed the request record width");
    end

    arb_state_e    state_q, state_d;
    logic [AW-1:0] scan_addr_q, scan_addr_d;
    logic          scan_done_q, scan_done_d;
    logic          drop_q, drop_d;          // in-flight scan read belongs to an old frame
    logic          underrun_q, underrun_d;
    logic          mem_req_q, mem_req_d;
    mem_req_t      req_q, req_d;
    logic          hack_q, hack_d;
    logic [DW-1:0] hrdata_q, hrdata_d;

    logic          fifo_push;
    logic          fifo_valid;
    logic [DW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fill;
    logic          scan_ok;
    mem_req_t      scan_req;
    mem_req_t      host_req;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (frame_start_i),
        .push_i  (fifo_push),
        .wdata_i (mem_rdata_i),
        .pop_i   (pix_rd_i),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        scan_done_d = scan_done_q;
        drop_d      = drop_q;
        underrun_d  = underrun_q;
        mem_req_d   = mem_req_q;
        req_d       = req_q;
        hack_d      = 1'b0;
        hrdata_d    = hrdata_q;
        fifo_push   = 1'b0;

        // A scan read in flight already owns a FIFO slot, so a push can
        // never find the FIFO full.
        fill = fifo_count + ((state_q == SCAN_WAIT) ? CW'(1) : CW'(0));

        // No scan read starts in the vsync cycle: the address is about to
        // be rewound and the old value must not leak out.
        scan_ok = !scan_done_q && !frame_start_i;

        scan_req.we    = 1'b0;
        scan_req.addr  = FB_ADDR_W'(scan_addr_q);
        scan_req.wdata = '0;
        host_req.we    = hwe_i;
        host_req.addr  = FB_ADDR_W'(haddr_i);
        host_req.wdata = FB_DATA_W'(hdata_i);

        case (state_q)
            IDLE: begin
                if (scan_ok && (fill < LOW_WM_C)) begin
                    state_d   = SCAN_WAIT;
                    mem_req_d = 1'b1;
                    req_d     = scan_req;
                end else if (hreq_i) begin
                    state_d   = HOST_WAIT;
                    mem_req_d = 1'b1;
                    req_d     = host_req;
                end else if (scan_ok && (fill < DEPTH_C)) begin
                    state_d   = SCAN_WAIT;
                    mem_req_d = 1'b1;
                    req_d     = scan_req;
                end
            end
            SCAN_WAIT: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!drop_q && !frame_start_i) begin
                        fifo_push = 1'b1;
                        if (scan_addr_q == FRAME_LAST) begin
                            scan_addr_d = '0;
                            scan_done_d = 1'b1;
                        end else begin
                            scan_addr_d = scan_addr_q + AW'(1);
                        end
                    end
                end
            end
            HOST_WAIT: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    hack_d    = 1'b1;
                    if (!req_q.we) begin
                        hrdata_d = mem_rdata_i;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (pix_rd_i && !fifo_valid) begin
            underrun_d = 1'b1;
        end

        // Vsync overrides everything scan-related, including the sticky flag.
        if (frame_start_i) begin
            scan_addr_d = '0;
            scan_done_d = 1'b0;
            underrun_d  = 1'b0;
            if ((state_q == SCAN_WAIT) && !mem_ack_i) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            scan_addr_q <= '0;
            scan_done_q <= 1'b1;
            drop_q      <= 1'b0;
            underrun_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            req_q       <= '0;
            hack_q      <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            scan_done_q <= scan_done_d;
            drop_q      <= drop_d;
            underrun_q  <= underrun_d;
            mem_req_q   <= mem_req_d;
            req_q       <= req_d;
            hack_q      <= hack_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign pix_o       = fifo_rdata;
    assign pix_valid_o = fifo_valid;
    assign underrun_o  = underrun_q;
    assign hack_o      = hack_q;
    assign hrdata_o    = hrdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = req_q.we;
    assign mem_addr_o  = req_q.addr[AW-1:0];
    assign mem_wdata_o = req_q.wdata[DW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fb_scan_arbiter.sv
// ============================================================================
//  Module   : tb_fb_scan_arbiter
//  Purpose  : Directed scoreboard bench for fb_scan_arbiter (4x2 frame,
//             4-deep FIFO, LOW_WM=2, memory returning data=address after a
//             two-cycle request-to-ack latency).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fb_scan_arbiter;

    localparam int WIDTH      = 4;
    localparam int HEIGHT     = 2;
    localparam int AW         = 17;
    localparam int DW         = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LOW_WM     = 2;
    localparam int MEM_LAT    = 2;   // cycles from mem_req_o rise to mem_ack_i rise

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          frame_start_i = 1'b0;
    logic          pix_rd_i = 1'b0;
    logic [DW-1:0] pix_o;
    logic          pix_valid_o;
    logic          underrun_o;
    logic          hreq_i = 1'b0;
    logic          hwe_i = 1'b0;
    logic [AW-1:0] haddr_i = '0;
    logic [DW-1:0] hdata_i = '0;
    logic          hack_o;
    logic [DW-1:0] hrdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    fb_scan_arbiter #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW), .DW(DW),
        .FIFO_DEPTH(FIFO_DEPTH), .LOW_WM(LOW_WM)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i),
        .pix_rd_i(pix_rd_i), .pix_o(pix_o), .pix_valid_o(pix_valid_o),
        .underrun_o(underrun_o), .hreq_i(hreq_i), .hwe_i(hwe_i),
        .haddr_i(haddr_i), .hdata_i(hdata_i), .hack_o(hack_o),
        .hrdata_o(hrdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic          is_host;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_exp_t;

    req_exp_t      req_q[$];
    logic [DW-1:0] pix_q[$];
    logic [DW-1:0] hrd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int req_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic exp_scan(input int a);
        req_exp_t e;
        e.is_host = 1'b0; e.we = 1'b0; e.addr = AW'(a); e.wdata = '0;
        req_q.push_back(e);
    endtask

    task automatic exp_host(input logic we, input int a, input logic [DW-1:0] d);
        req_exp_t e;
        e.is_host = 1'b1; e.we = we; e.addr = AW'(a); e.wdata = d;
        req_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_start_i = 1'b1;
        tick(1);
        frame_start_i = 1'b0;
    endtask

    task automatic wait_hack(input int budget, output int lat);
        lat = 0;
        while (!hack_o && lat < budget) begin
            tick(1);
            lat++;
        end
        if (!hack_o) fail_now("hack_timeout");
    endtask

    // ---------------- memory model: data = address, fixed latency --------
    logic [DW-1:0] mem_model [0:31];
    int lat_cnt = 0;
    initial begin
        for (int i = 0; i < 32; i++) mem_model[i] = DW'(i);
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (!rst_ni || !mem_req_o) begin
                lat_cnt = 0;
            end else begin
                lat_cnt++;
                if (lat_cnt == MEM_LAT + 1) begin
                    if (mem_we_o) mem_model[mem_addr_o[4:0]] = mem_wdata_o;
                    mem_rdata_i = mem_model[mem_addr_o[4:0]];
                    mem_ack_i   = 1'b1;
                    lat_cnt     = 0;
                end
            end
        end
    end

    // ---------------- monitor -------------------------------------------
    logic          prev_req = 1'b0;
    logic          cur_host = 1'b0;
    logic          cur_we = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic          ack_host_d = 1'b0;
    req_exp_t      mon_e;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_req   = 1'b0;
            ack_host_d = 1'b0;
        end else begin
            if (ack_host_d || hack_o) check("hack_pulse", hack_o, ack_host_d);
            if (hack_o && ack_host_d && !cur_we) begin
                if (hrd_q.size() == 0) fail_now("unexpected_host_read_data");
                else check("hrdata", hrdata_o, hrd_q.pop_front());
            end
            ack_host_d = mem_req_o && mem_ack_i && cur_host;

            if (mem_req_o && !prev_req) begin
                req_seen++;
                cur_we    = mem_we_o;
                cur_addr  = mem_addr_o;
                cur_wdata = mem_wdata_o;
                if (req_q.size() == 0) begin
                    cur_host = 1'b0;
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h we %0b, required none (t=%0t)",
                             mem_addr_o, mem_we_o, $time);
                end else begin
                    mon_e    = req_q.pop_front();
                    cur_host = mon_e.is_host;
                    check("req_we", mem_we_o, mon_e.we);
                    check("req_addr", mem_addr_o, mon_e.addr);
                    if (mon_e.we) check("req_wdata", mem_wdata_o, mon_e.wdata);
                end
            end else if (mem_req_o) begin
                check("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, {cur_we, cur_addr, cur_wdata});
            end
            prev_req = mem_req_o;

            if (pix_rd_i && pix_valid_o) begin
                if (pix_q.size() == 0) fail_now("unexpected_pixel_pop");
                else check("pixel", pix_o, pix_q.pop_front());
            end
        end
    end

    // ---------------- watchdog -------------------------------------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus -------------------------------------------
    int lat;
    initial begin
        // Reset state
        tick(3);
        check("rst_flags", {pix_valid_o, underrun_o, hack_o, mem_req_o, mem_we_o}, 0);
        check("rst_pix", pix_o, 0);
        check("rst_hrdata", hrdata_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        rst_ni = 1'b1;
        tick(5);
        check("no_scan_before_frame", req_seen, 0);

        // Fill with no pops: reads 0..3, FIFO full, head pixel 0
        for (int a = 0; a < 4; a++) exp_scan(a);
        pulse_frame();
        tick(30);
        check("fill_req_count", req_seen, 4);
        check("fill_pending", req_q.size(), 0);
        check("fill_valid", pix_valid_o, 1);
        check("fill_head", pix_o, 0);

        // Continuous pop: pixels 0..7 in order, then scan stops at frame end
        for (int p = 0; p < 8; p++) pix_q.push_back(DW'(p));
        for (int a = 4; a < 8; a++) exp_scan(a);
        pix_rd_i = 1'b1;
        tick(60);
        pix_rd_i = 1'b0;
        check("frame_pixels_left", pix_q.size(), 0);
        check("frame_req_count", req_seen, 8);
        check("underrun_set", underrun_o, 1);
        tick(10);
        check("underrun_sticky", underrun_o, 1);
        check("scan_done_no_req", req_seen, 8);

        // Restart: address back to 0, underrun cleared
        for (int a = 0; a < 4; a++) exp_scan(a);
        pulse_frame();
        check("underrun_cleared", underrun_o, 0);
        tick(30);
        check("restart_pending", req_q.size(), 0);
        check("restart_head", pix_o, 0);

        // FIFO above LOW_WM: host write served before next scan read
        exp_host(1'b1, 'h10, 16'hABCD);
        exp_scan(4);
        pix_q.push_back(16'd0);
        hwe_i = 1'b1; haddr_i = AW'('h10); hdata_i = 16'hABCD; hreq_i = 1'b1;
        pix_rd_i = 1'b1;
        tick(1);
        pix_rd_i = 1'b0;
        wait_hack(30, lat);
        hreq_i = 1'b0;
        check("host_latency", lat + 1, MEM_LAT + 2);
        tick(12);
        check("host_wr_pending", req_q.size(), 0);

        // FIFO below LOW_WM: urgent scan reads before the host read
        exp_scan(5);
        exp_scan(6);
        exp_host(1'b0, 'h10, '0);
        hrd_q.push_back(16'hABCD);
        exp_scan(7);
        for (int p = 1; p < 5; p++) pix_q.push_back(DW'(p));
        pix_rd_i = 1'b1;
        tick(3);
        hwe_i = 1'b0; haddr_i = AW'('h10); hreq_i = 1'b1;
        tick(1);
        pix_rd_i = 1'b0;
        wait_hack(40, lat);
        hreq_i = 1'b0;
        tick(15);
        check("urgent_pending", req_q.size(), 0);
        check("urgent_pixels_left", pix_q.size(), 0);
        check("hrd_left", hrd_q.size(), 0);
        check("urgent_head", pix_o, 5);

        // frame_start while scan read of address 5 is outstanding
        for (int a = 0; a < 6; a++) exp_scan(a);
        for (int p = 0; p < 5; p++) pix_q.push_back(DW'(p));
        pulse_frame();
        pix_rd_i = 1'b1;
        lat = 0;
        while (!(mem_req_o && mem_addr_o == AW'(5)) && lat < 80) begin
            tick(1);
            lat++;
        end
        if (!(mem_req_o && mem_addr_o == AW'(5))) fail_now("addr5_timeout");
        for (int a = 0; a < 4; a++) exp_scan(a);
        frame_start_i = 1'b1;
        pix_rd_i = 1'b0;
        tick(1);
        frame_start_i = 1'b0;
        lat = 0;
        while (mem_req_o && lat < 20) begin tick(1); lat++; end
        while (!mem_req_o && lat < 20) begin tick(1); lat++; end
        if (!mem_req_o) fail_now("restart_req_timeout");
        check("drop_fifo_empty", pix_valid_o, 0);
        check("drop_underrun_cleared", underrun_o, 0);
        tick(30);
        check("drop_pending", req_q.size(), 0);
        check("drop_pixels_left", pix_q.size(), 0);
        check("drop_head", pix_o, 0);

        // Reset in the middle of a host transaction
        exp_host(1'b1, 'h11, 16'h1234);
        hwe_i = 1'b1; haddr_i = AW'('h11); hdata_i = 16'h1234; hreq_i = 1'b1;
        lat = 0;
        while (!mem_req_o && lat < 10) begin tick(1); lat++; end
        if (!mem_req_o) fail_now("host_req_timeout");
        tick(1);
        #2;
        rst_ni = 1'b0;
        hreq_i = 1'b0;
        tick(1);
        check("midrst_flags", {pix_valid_o, underrun_o, hack_o, mem_req_o, mem_we_o}, 0);
        check("midrst_pix", pix_o, 0);
        check("midrst_hrdata", hrdata_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_mem_wdata", mem_wdata_o, 0);
        rst_ni = 1'b1;
        lat = req_seen;
        tick(10);
        check("post_rst_no_req", req_seen, lat);
        check("post_rst_pending", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
